// File: rtl/npu_host_bridge.sv
// Host-side NPU front end: buffers one job from a valid/ready stream, replays it
// as a gap-free write burst on the shared bus, then drains results back to the host.
module npu_host_bridge #(
    parameter int unsigned DEPTH     = 2048,
    parameter int unsigned AW        = 11,
    parameter int unsigned HDR_WORDS = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    input  logic        in_last,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        out_last,
    inout  wire  [31:0] npu_data,
    output logic        npu_we,
    output logic        npu_oe,
    input  logic        npu_ready,
    output logic        busy,
    output logic        err
);
    localparam int unsigned CW       = AW + 1;
    localparam logic [CW-1:0] HDR_LEN  = CW'(HDR_WORDS);
    localparam logic [CW-1:0] LAST_IDX = CW'(DEPTH - 1);
    localparam logic [CW-1:0] NOUT_IDX = CW'(4);

    typedef enum logic [2:0] {IDLE, FILL, BURST, WAIT, DRAIN} state_t;

    state_t        state;
    logic [31:0]   mem [DEPTH];
    logic [31:0]   rd_data;
    logic [CW-1:0] wr_ptr;
    logic [CW-1:0] len;
    logic [CW-1:0] burst_idx;
    logic [5:0]    n_out;
    logic [5:0]    rd_cnt;
    logic          drop;
    logic          accept;
    logic          wr_en;
    logic          capture;
    logic          consume;
    logic [AW-1:0] wr_addr;
    logic [AW-1:0] rd_addr;

    assign accept  = in_valid & in_ready;
    assign wr_en   = accept & ((state == IDLE) | ((state == FILL) & ~drop));
    assign wr_addr = (state == FILL) ? wr_ptr[AW-1:0] : '0;
    // Prefetch one word ahead so burst data is valid on every npu_we cycle
    assign rd_addr = (state == BURST) ? AW'(burst_idx + 1'b1) : '0;

    assign capture = (state == DRAIN) & npu_ready & (~out_valid | out_ready) & (rd_cnt < n_out);
    assign consume = out_valid & out_ready;
    assign npu_oe  = capture;
    assign npu_data = npu_we ? rd_data : {32{1'bz}};

    // Job buffer with registered read port
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= in_data;
        end
        rd_data <= mem[rd_addr];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b0;
            busy      <= 1'b0;
            err       <= 1'b0;
            npu_we    <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
            wr_ptr    <= '0;
            len       <= '0;
            burst_idx <= '0;
            n_out     <= '0;
            rd_cnt    <= '0;
            drop      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    in_ready <= 1'b1;
                    if (accept) begin
                        err    <= in_last;
                        wr_ptr <= CW'(1);
                        drop   <= 1'b0;
                        if (!in_last) begin
                            state <= FILL;
                            busy  <= 1'b1;
                        end
                    end
                end
                FILL: begin
                    if (accept && drop) begin
                        // Overflowed job: swallow words until the host ends it
                        if (in_last) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            drop  <= 1'b0;
                        end
                    end else if (accept) begin
                        wr_ptr <= wr_ptr + 1'b1;
                        if (wr_ptr == NOUT_IDX) begin
                            n_out <= 6'(in_data[4:0]) + 6'd1;
                        end
                        if (in_last) begin
                            if (wr_ptr + 1'b1 < HDR_LEN) begin
                                err   <= 1'b1;
                                state <= IDLE;
                                busy  <= 1'b0;
                            end else begin
                                len       <= wr_ptr + 1'b1;
                                burst_idx <= '0;
                                npu_we    <= 1'b1;
                                in_ready  <= 1'b0;
                                state     <= BURST;
                            end
                        end else if (wr_ptr == LAST_IDX) begin
                            err  <= 1'b1;
                            drop <= 1'b1;
                        end
                    end
                end
                BURST: begin
                    if (burst_idx == len - 1'b1) begin
                        npu_we <= 1'b0;
                        state  <= WAIT;
                    end else begin
                        burst_idx <= burst_idx + 1'b1;
                    end
                end
                WAIT: begin
                    if (npu_ready) begin
                        rd_cnt <= '0;
                        state  <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (capture) begin
                        out_data  <= npu_data;
                        out_valid <= 1'b1;
                        out_last  <= (rd_cnt == n_out - 6'd1);
                        rd_cnt    <= rd_cnt + 6'd1;
                    end else if (consume) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        if (out_last) begin
                            state    <= IDLE;
                            busy     <= 1'b0;
                            in_ready <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_npu_host_bridge.sv
// Bench for npu_host_bridge (DEPTH=16 build): directed jobs plus randomized
// jobs and handshakes, checked against a job-level reference model.
module tb_npu_host_bridge;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned AW    = 4;

    typedef logic [31:0] wq_t[$];

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_last;
    wire  [31:0] npu_data;
    logic        npu_we;
    logic        npu_oe;
    logic        npu_ready;
    logic        busy;
    logic        err;

    int total = 0;
    int bad   = 0;

    npu_host_bridge #(.DEPTH(DEPTH), .AW(AW), .HDR_WORDS(6)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .npu_data(npu_data), .npu_we(npu_we), .npu_oe(npu_oe), .npu_ready(npu_ready),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    // NPU result model: the k-th read pulse ever issued returns res_mem[k]
    logic [31:0] res_mem [4096];
    logic [11:0] oe_cnt = 12'd0;
    assign npu_data = (npu_oe === 1'b1) ? res_mem[oe_cnt] : {32{1'bz}};
    always @(posedge clk) if (npu_oe === 1'b1) oe_cnt <= oe_cnt + 12'd1;

    logic [31:0] burst_q[$];
    logic [32:0] got_q[$];
    int   we_rises = 0;
    int   both_on  = 0;
    logic we_prev  = 1'b0;
    always @(negedge clk) begin
        if (npu_we === 1'b1) burst_q.push_back(npu_data);
        if (npu_we === 1'b1 && we_prev !== 1'b1) we_rises <= we_rises + 1;
        we_prev <= npu_we;
        if (npu_we === 1'b1 && npu_oe === 1'b1) both_on <= both_on + 1;
        if (out_valid === 1'b1 && out_ready === 1'b1) got_q.push_back({out_last, out_data});
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic wq_t make_job(input logic [4:0] w4, input int len);
        wq_t q;
        logic [31:0] t;
        for (int i = 0; i < len; i++) begin
            t = $urandom;
            if (i == 4) t[4:0] = w4;
            q.push_back(t);
        end
        return q;
    endfunction

    task automatic send_job(input wq_t w);
        int guard;
        bit ok;
        for (int i = 0; i < w.size(); i++) begin
            guard = 0;
            ok = 1'b0;
            in_valid = 1'b1;
            in_data  = w[i];
            in_last  = (i == w.size() - 1);
            while (!ok && guard < 50) begin
                @(negedge clk);
                ok = (in_ready === 1'b1);
                tick();
                guard++;
            end
            if (!ok) begin
                check("send_ack", 64'(ok), 64'(1));
                break;
            end
            if (i == 0 && w.size() > 1) check("err_clear_first", 64'(err), 64'(0));
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic drain(input bit rnd, input int bound);
        int n = 0;
        while (busy === 1'b1 && n < bound) begin
            npu_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            out_ready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
            tick();
            n++;
        end
        npu_ready = 1'b0;
        out_ready = 1'b1;
        check("drain_done", 64'(busy), 64'(0));
    endtask

    task automatic gen_res(input int n, output wq_t er);
        logic [31:0] t;
        er = {};
        for (int i = 0; i < n; i++) begin
            t = $urandom;
            er.push_back(t);
            res_mem[oe_cnt + 12'(i)] = t;
        end
    endtask

    task automatic verify_burst(input int b0, input int r0, input wq_t w);
        check("burst_len", 64'(burst_q.size() - b0), 64'(w.size()));
        check("we_pulses", 64'(we_rises - r0), 64'(1));
        for (int i = 0; i < w.size() && b0 + i < burst_q.size(); i++)
            check("burst_word", 64'(burst_q[b0 + i]), 64'(w[i]));
    endtask

    task automatic verify_out(input int g0, input logic [11:0] o0, input wq_t er);
        int n = er.size();
        check("oe_pulses", 64'(oe_cnt - o0), 64'(n));
        check("out_count", 64'(got_q.size() - g0), 64'(n));
        for (int i = 0; i < n && g0 + i < got_q.size(); i++)
            check("out_word", 64'(got_q[g0 + i]), 64'({(i == n - 1), er[i]}));
    endtask

    task automatic run_job(input wq_t w, input bit rnd);
        wq_t er;
        int b0, g0, r0;
        logic [11:0] o0;
        gen_res(int'(w[4][4:0]) + 1, er);
        b0 = burst_q.size(); g0 = got_q.size(); r0 = we_rises; o0 = oe_cnt;
        npu_ready = 1'b0;
        out_ready = 1'b1;
        send_job(w);
        drain(rnd, 2000);
        verify_burst(b0, r0, w);
        verify_out(g0, o0, er);
        check("err_after_job", 64'(err), 64'(0));
    endtask

    wq_t job, er;
    int  b0, g0, r0, k;
    logic [11:0] o0;

    initial begin
        in_valid = 1'b0; in_data = 32'd0; in_last = 1'b0;
        out_ready = 1'b1; npu_ready = 1'b0;
        rst = 1'b1;
        repeat (3) tick();
        check("rst_in_ready", 64'(in_ready), 64'(0));
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_out_last", 64'(out_last), 64'(0));
        check("rst_out_data", 64'(out_data), 64'(0));
        check("rst_npu_we", 64'(npu_we), 64'(0));
        check("rst_npu_oe", 64'(npu_oe), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_err", 64'(err), 64'(0));
        rst = 1'b0;
        tick(); tick();
        check("idle_in_ready", 64'(in_ready), 64'(1));

        // Minimal job: n_out = 2, 11 words
        job = {32'd0, 32'd1, 32'd0, 32'd0, 32'd1, 32'd0};
        for (int i = 0; i < 5; i++) job.push_back($urandom);
        run_job(job, 1'b0);

        // Output backpressure with n_out = 4
        job = make_job(5'd3, 8);
        gen_res(4, er);
        b0 = burst_q.size(); g0 = got_q.size(); r0 = we_rises; o0 = oe_cnt;
        npu_ready = 1'b0; out_ready = 1'b0;
        send_job(job);
        npu_ready = 1'b1;
        k = 0;
        while (out_valid !== 1'b1 && k < 100) begin tick(); k++; end
        check("bp_first_cap", 64'(out_valid), 64'(1));
        repeat (5) tick();
        check("bp_stall_oe", 64'(oe_cnt - o0), 64'(1));
        check("bp_stall_out", 64'(got_q.size() - g0), 64'(0));
        check("bp_hold_data", 64'(out_data), 64'(er[0]));
        drain(1'b0, 200);
        verify_burst(b0, r0, job);
        verify_out(g0, o0, er);

        // Short job: in_last on the 4th word
        r0 = we_rises;
        send_job(make_job(5'd0, 4));
        repeat (3) tick();
        check("short_err", 64'(err), 64'(1));
        check("short_no_burst", 64'(we_rises - r0), 64'(0));
        check("short_busy", 64'(busy), 64'(0));
        check("short_in_ready", 64'(in_ready), 64'(1));

        // Shortest legal job (header only), also clears the sticky error
        run_job(make_job(5'd0, 6), 1'b0);

        // Overflow: 20 words into a 16-word buffer
        r0 = we_rises;
        send_job(make_job(5'd2, 20));
        repeat (3) tick();
        check("ovf_err", 64'(err), 64'(1));
        check("ovf_no_burst", 64'(we_rises - r0), 64'(0));
        check("ovf_in_ready", 64'(in_ready), 64'(1));
        check("ovf_busy", 64'(busy), 64'(0));

        // Reset during burst cycle 3
        npu_ready = 1'b0;
        send_job(make_job(5'd1, 10));
        k = 0;
        while (npu_we !== 1'b1 && k < 20) begin tick(); k++; end
        check("rb_burst_start", 64'(npu_we), 64'(1));
        repeat (3) tick();
        check("rb_cycle3_we", 64'(npu_we), 64'(1));
        rst = 1'b1;
        #1;
        check("rb_we_off", 64'(npu_we), 64'(0));
        check("rb_busy_off", 64'(busy), 64'(0));
        tick();
        rst = 1'b0;
        tick(); tick();
        check("rb_busy_after", 64'(busy), 64'(0));
        check("rb_in_ready_after", 64'(in_ready), 64'(1));
        run_job(make_job(5'd6, 12), 1'b0);

        // n_out = 32 on a full-depth job, random handshakes
        run_job(make_job(5'd31, 16), 1'b1);

        // Random jobs
        for (int j = 0; j < 4; j++)
            run_job(make_job(5'($urandom), $urandom_range(6, 16)), 1'b1);

        check("we_oe_exclusive", 64'(both_on), 64'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
